// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the four-slot TDM receive path.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Tracks the bit position within a slot and the slot position within a frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              clear,
    input  logic              load_first,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [SLOT_W-1:0] slot,
    output logic              at_frame_start,
    output logic              at_frame_end
);

    // load_first marks that slot 0, bit 0 was just consumed, so the next bit is bit 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            slot    <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            slot    <= '0;
        end else if (load_first) begin
            bit_cnt <= CNT_W'(1);
            slot    <= '0;
        end else if (advance) begin
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                bit_cnt <= '0;
                slot    <= slot + SLOT_W'(1);
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign at_frame_start = (slot == '0) && (bit_cnt == '0);
    assign at_frame_end   = (slot == SLOT_W'(NUM_SLOTS - 1)) && (bit_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Splits a serial four-slot TDM stream into parallel channel words, using
// frame_sync to acquire and police frame alignment.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SLOT_W-1:0]  slot;
    logic               at_frame_start, at_frame_end;
    logic               cnt_advance, cnt_clear, cnt_load_first;
    logic               shift_en, frame_done, err_d;
    logic [SLOT_W-1:0]  shift_slot;
    logic [WIDTH-1:0]   shadow [NUM_SLOTS];

    tdm_slot_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_counter (
        .clk            (clk),
        .rst            (rst),
        .advance        (cnt_advance),
        .clear          (cnt_clear),
        .load_first     (cnt_load_first),
        .bit_cnt        (bit_cnt),
        .slot           (slot),
        .at_frame_start (at_frame_start),
        .at_frame_end   (at_frame_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_HUNT;
        else     state_q <= state_d;
    end

    // A resync bit always lands in slot 0; stale bits left in other shadows are
    // fully overwritten before the frame can complete.
    always_comb begin
        state_d        = state_q;
        cnt_advance    = 1'b0;
        cnt_clear      = 1'b0;
        cnt_load_first = 1'b0;
        shift_en       = 1'b0;
        shift_slot     = '0;
        frame_done     = 1'b0;
        err_d          = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        shift_en       = 1'b1;
                        cnt_load_first = 1'b1;
                        state_d        = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (frame_sync && !at_frame_start) begin
                        err_d          = 1'b1;
                        shift_en       = 1'b1;
                        cnt_load_first = 1'b1;
                    end else if (!frame_sync && at_frame_start) begin
                        err_d     = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        shift_en    = 1'b1;
                        shift_slot  = slot;
                        cnt_advance = 1'b1;
                        frame_done  = at_frame_end;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // The final bit of slot 3 is folded straight into ch3 as it arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            sync_err    <= err_d;
            if (shift_en)
                shadow[shift_slot] <= {shadow[shift_slot][WIDTH-2:0], din};
            if (frame_done) begin
                ch0 <= shadow[0];
                ch1 <= shadow[1];
                ch2 <= shadow[2];
                ch3 <= {shadow[3][WIDTH-2:0], din};
            end
        end
    end

    assign locked = (state_q == ST_RECV);

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomised scoreboard bench for tdm_demux4 against a frame-position reference model.
module tb_tdm_demux4;

    localparam int W  = 8;
    localparam int FB = 4 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [W-1:0]  ch0, ch1, ch2, ch3;
    logic          frame_valid, sync_err, locked;

    int checks = 0;
    int errors = 0;

    logic          m_locked = 1'b0;
    int            m_pos = 0;
    logic          m_bits [FB];
    logic [FB-1:0] m_ch = '0;
    logic [FB-1:0] exp_frames [$];
    bit            exp_errs [$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame words are rebuilt from the raw bit list once all 4*W bits are in
    task automatic storeBit(input logic d);
        logic [FB-1:0] f;
        logic [W-1:0]  w;
        m_bits[m_pos] = d;
        m_pos++;
        if (m_pos == FB) begin
            f = '0;
            for (int s = 0; s < 4; s++) begin
                w = '0;
                for (int i = 0; i < W; i++) w = (w << 1) | W'(m_bits[s*W + i]);
                f = {f[FB-W-1:0], w};
            end
            exp_frames.push_back(f);
            m_pos = 0;
        end
    endtask

    task automatic modelAccept(input logic d, input logic fs);
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_pos    = 0;
                storeBit(d);
            end
        end else if (fs && m_pos != 0) begin
            exp_errs.push_back(1'b1);
            m_pos = 0;
            storeBit(d);
        end else if (!fs && m_pos == 0) begin
            exp_errs.push_back(1'b1);
            m_locked = 1'b0;
        end else begin
            storeBit(d);
        end
    endtask

    // Idle cycles carry random din/frame_sync garbage that must be ignored
    task automatic applyStimulus(input logic d, input logic fs, input int gap);
        repeat (gap) begin
            din_valid  = 1'b0;
            din        = 1'($urandom);
            frame_sync = 1'($urandom);
            @(posedge clk);
            #1;
        end
        din_valid  = 1'b1;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        modelAccept(d, fs);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    // mode 0: continuous, 1: every other cycle, 2: random gaps
    task automatic sendFrame(input logic [FB-1:0] f, input int nbits, input int mode, input int long_gap_at);
        int gap;
        for (int i = 0; i < nbits; i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            if (i == long_gap_at) gap += 5;
            applyStimulus(f[FB-1-i], (i == 0), gap);
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        m_locked = 1'b0;
        m_pos    = 0;
        m_ch     = '0;
        exp_frames.delete();
        exp_errs.delete();
        #1;
        checkOutput("reset_channels", {ch0, ch1, ch2, ch3}, '0);
        checkOutput("reset_flags", FB'({frame_valid, sync_err, locked}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sync_err) begin
                checks++;
                if (exp_errs.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_sync_err actual=1 expected=0 at %0t", $time);
                end else begin
                    void'(exp_errs.pop_front());
                end
            end
            if (frame_valid) begin
                checks++;
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_frame_valid actual=1 expected=0 at %0t", $time);
                end else begin
                    m_ch = exp_frames.pop_front();
                end
            end
            checkOutput("pending_frame_valid", FB'(exp_frames.size()), '0);
            checkOutput("pending_sync_err", FB'(exp_errs.size()), '0);
            checkOutput("channels", {ch0, ch1, ch2, ch3}, m_ch);
            checkOutput("locked", FB'(locked), FB'(m_locked));
        end
    end

    initial begin
        logic [FB-1:0] f;
        int r;
        doReset();

        sendFrame(32'hA5_3C_FF_01, FB, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        doReset();

        sendFrame(32'hA5_3C_FF_01, FB, 1, 20);
        sendFrame(32'hA5_3C_FF_01, FB, 0, -1);
        sendFrame(32'h11_22_33_44, FB, 0, -1);

        sendFrame(32'hDE_AD_BE_EF, 12, 0, -1);
        sendFrame(32'h5A_C3_0F_96, FB, 0, -1);

        applyStimulus(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'($urandom), 1'b0, 0);
        sendFrame(32'h12_34_56_78, FB, 2, -1);

        sendFrame(32'hCA_FE_BA_BE, 20, 0, -1);
        #2;
        doReset();
        sendFrame(32'h0F_F0_AA_55, FB, 0, -1);

        for (int n = 0; n < 40; n++) begin
            f = FB'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                sendFrame(f, int'($urandom_range(1, FB - 1)), 2, -1);
            end else if (r == 1) begin
                for (int i = 0; i < 4; i++) applyStimulus(1'($urandom), 1'b0, int'($urandom_range(0, 1)));
            end else begin
                sendFrame(f, FB, 2, int'($urandom_range(0, FB - 1)));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_frames_drained", FB'(exp_frames.size()), '0);
        checkOutput("final_errs_drained", FB'(exp_errs.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
